vecmac_seq_ctrl: RTL and testbench

//  Sequencer for the 4-lane int8 multiply datapath (4x 8x8 unsigned products, 18-bit lane sum).

---
 rtl/vecmac_seq_ctrl.sv | 168 ++++++++++++++++
 tb/tb_vecmac_seq_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vecmac_seq_ctrl.sv
// Sequencer for the 4-lane int8 multiply datapath: streams operand words, tracks in-flight
// issues, accumulates lane sums into one dot-product result. Define VECMAC_SAT_EN to saturate on overflow.
module vecmac_seq_ctrl #(
    parameter int LEN_W   = 16,
    parameter int ACC_W   = 32,
    parameter int MAX_OUT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] vec_len,
    input  logic             abort,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    output logic             dp_in_valid,
    output logic [31:0]      dp_in_a,
    output logic [31:0]      dp_in_b,
    input  logic             dp_out_valid,
    input  logic [17:0]      dp_out_sum,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_acc,
    output logic             res_ovf
);

    localparam int OUT_W = $clog2(MAX_OUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE,
        S_FLUSH
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   issued_q, issued_d;
    logic [OUT_W-1:0]   outst_q, outst_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic               dpv_q, dpv_d;
    logic [31:0]        dpa_q, dpa_d;
    logic [31:0]        dpb_q, dpb_d;

    logic               hs;
    logic               ret;
    logic               acc_en;
    logic [ACC_W:0]     sum_wide;

    assign in_ready = (state_q == S_RUN) && (issued_q < len_q)
                      && (outst_q < OUT_W'(MAX_OUT)) && !abort;
    assign hs       = in_valid && in_ready;
    // Returns only count while something can be in flight; stray valids never underflow outst.
    assign ret      = dp_out_valid && (outst_q != '0)
                      && (state_q inside {S_RUN, S_DRAIN, S_FLUSH});
    assign acc_en   = dp_out_valid && !abort && (state_q inside {S_RUN, S_DRAIN});
    assign sum_wide = {1'b0, acc_q} + (ACC_W + 1)'(dp_out_sum);

    // NOTE: every next-state variable gets its hold value first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        issued_d = issued_q;
        outst_d  = outst_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        dpv_d    = hs;
        dpa_d    = hs ? in_a : dpa_q;
        dpb_d    = hs ? in_b : dpb_q;

        if (hs && !ret) begin
            outst_d = outst_q + OUT_W'(1);
        end else if (!hs && ret) begin
            outst_d = outst_q - OUT_W'(1);
        end

        if (hs) begin
            issued_d = issued_q + LEN_W'(1);
        end

        if (acc_en) begin
`ifdef VECMAC_SAT_EN
            acc_d = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
            acc_d = sum_wide[ACC_W-1:0];
`endif
            if (sum_wide[ACC_W]) begin
                ovf_d = 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    len_d    = vec_len;
                    acc_d    = '0;
                    ovf_d    = 1'b0;
                    issued_d = '0;
                    state_d  = (vec_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_FLUSH;
                end else if (hs && ((issued_q + LEN_W'(1)) == len_q)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Wait for the final sum to land in acc before presenting the result.
                if (abort) begin
                    state_d = S_FLUSH;
                end else if ((outst_q == '0) && !dp_out_valid) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (abort || res_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (outst_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            issued_q <= '0;
            outst_q  <= '0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            dpv_q    <= 1'b0;
            dpa_q    <= '0;
            dpb_q    <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            issued_q <= issued_d;
            outst_q  <= outst_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
            dpv_q    <= dpv_d;
            dpa_q    <= dpa_d;
            dpb_q    <= dpb_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign dp_in_valid = dpv_q;
    assign dp_in_a     = dpa_q;
    assign dp_in_b     = dpb_q;
    assign res_valid   = (state_q == S_DONE);
    assign res_acc     = acc_q;
    assign res_ovf     = ovf_q;

endmodule

// File: tb/tb_vecmac_seq_ctrl.sv
// Directed bench for vecmac_seq_ctrl with a 3-stage 4-lane multiply datapath model.
// Build with VECMAC_SAT_EN defined to check the saturating accumulator variant.
module tb_vecmac_seq_ctrl;

    localparam int LEN_W   = 16;
    localparam int ACC_W   = 20;
    localparam int MAX_OUT = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] vec_len;
    logic             abort;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic             dp_in_valid;
    logic [31:0]      dp_in_a;
    logic [31:0]      dp_in_b;
    logic             dp_out_valid;
    logic [17:0]      dp_out_sum;
    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] res_acc;
    logic             res_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] wa [16];
    logic [31:0] wb [16];

    always #5 clk = ~clk;

    vecmac_seq_ctrl #(.LEN_W(LEN_W), .ACC_W(ACC_W), .MAX_OUT(MAX_OUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .vec_len      (vec_len),
        .abort        (abort),
        .busy         (busy),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .dp_in_valid  (dp_in_valid),
        .dp_in_a      (dp_in_a),
        .dp_in_b      (dp_in_b),
        .dp_out_valid (dp_out_valid),
        .dp_out_sum   (dp_out_sum),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_acc      (res_acc),
        .res_ovf      (res_ovf)
    );

    function automatic logic [17:0] lane_sum(input logic [31:0] a, input logic [31:0] b);
        logic [17:0] s = '0;
        for (int k = 0; k < 4; k++) s += 18'(a[8*k +: 8]) * 18'(b[8*k +: 8]);
        return s;
    endfunction

    // Datapath model: fixed 3-cycle latency, flushed by rst_n.
    logic        pv [3];
    logic [17:0] ps [3];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                pv[i] <= 1'b0;
                ps[i] <= '0;
            end
        end else begin
            pv[0] <= dp_in_valid;
            ps[0] <= lane_sum(dp_in_a, dp_in_b);
            for (int i = 1; i < 3; i++) begin
                pv[i] <= pv[i-1];
                ps[i] <= ps[i-1];
            end
        end
    end
    assign dp_out_valid = pv[2];
    assign dp_out_sum   = ps[2];

    int dp_pulses = 0;
    int occ       = 0;
    int occ_viol  = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) occ <= 0;
        else begin
            occ <= occ + int'(dp_in_valid) - int'(dp_out_valid);
            if (dp_in_valid) dp_pulses <= dp_pulses + 1;
        end
    end
    always @(negedge clk) if (occ > MAX_OUT) occ_viol++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int len);
        start   = 1'b1;
        vec_len = LEN_W'(len);
        tick();
        start   = 1'b0;
    endtask

    task automatic feed(input int len, input bit rnd, input int stop_at, output int accepted);
        int  idx = 0;
        int  budget = 0;
        bit  hs;
        while (idx < len && idx != stop_at && budget < 2000) begin
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_a     = wa[idx];
            in_b     = wb[idx];
            @(negedge clk);
            hs = in_valid && in_ready;
            tick();
            if (hs) idx++;
            budget++;
        end
        in_valid = 1'b0;
        accepted = idx;
        if (idx < len && idx != stop_at) check("feed_timeout", 32'(idx), 32'(len));
    endtask

    task automatic wait_result();
        int n = 0;
        while (!res_valid && n < 500) begin
            tick();
            n++;
        end
        if (!res_valid) check("result_timeout", 32'(res_valid), 32'd1);
    endtask

    task automatic take_result();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("res_valid_dropped", 32'(res_valid), 32'd0);
        check("idle_after_result", 32'(busy), 32'd0);
    endtask

    task automatic fill(input int len, input logic [31:0] w);
        for (int i = 0; i < len; i++) begin
            wa[i] = w;
            wb[i] = w;
        end
    endtask

    function automatic logic [ACC_W:0] golden(input int len);
        longint s = 0;
        for (int i = 0; i < len; i++) s += longint'(lane_sum(wa[i], wb[i]));
        if (s >= (longint'(1) << ACC_W)) begin
`ifdef VECMAC_SAT_EN
            return {1'b1, {ACC_W{1'b1}}};
`else
            return {1'b1, ACC_W'(s)};
`endif
        end
        return {1'b0, ACC_W'(s)};
    endfunction

    initial begin
        int           acc_n;
        int           p0;
        int           n;
        logic [ACC_W:0] g;
        logic [ACC_W-1:0] held;
        bit           saw_res;

        rst_n = 1'b0; start = 1'b0; vec_len = '0; abort = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_dp_in_valid", 32'(dp_in_valid), 32'd0);
        check("rst_dp_in_a", dp_in_a, 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_acc", 32'(res_acc), 32'd0);
        check("rst_res_ovf", 32'(res_ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // T1: three words of ones -> 4 per word.
        fill(3, 32'h01010101);
        p0 = dp_pulses;
        start_job(3);
        check("t1_busy", 32'(busy), 32'd1);
        feed(3, 1'b0, -1, acc_n);
        check("t1_accepted", 32'(acc_n), 32'd3);
        wait_result();
        check("t1_res_acc", 32'(res_acc), 32'd12);
        check("t1_res_ovf", 32'(res_ovf), 32'd0);
        check("t1_dp_pulses", 32'(dp_pulses - p0), 32'd3);
        take_result();

        // T2: zero-length job; start while in DONE is ignored.
        p0 = dp_pulses;
        start_job(0);
        n = 1;
        while (!res_valid && n < 2) begin
            tick();
            n++;
        end
        check("t2_res_valid", 32'(res_valid), 32'd1);
        check("t2_res_acc", 32'(res_acc), 32'd0);
        start_job(5);
        check("t2_start_in_done", 32'(res_valid), 32'd1);
        check("t2_in_ready_done", 32'(in_ready), 32'd0);
        check("t2_dp_pulses", 32'(dp_pulses - p0), 32'd0);
        take_result();

        // T3: 5 x 260100 overflows a 20-bit accumulator.
        fill(5, 32'hFFFFFFFF);
        start_job(5);
        feed(5, 1'b0, -1, acc_n);
        wait_result();
`ifdef VECMAC_SAT_EN
        check("t3_res_acc", 32'(res_acc), 32'hFFFFF);
`else
        check("t3_res_acc", 32'(res_acc), 32'd251924);
`endif
        check("t3_res_ovf", 32'(res_ovf), 32'd1);
        take_result();

        // T4: 16 varied words, random in_valid, result held while res_ready low.
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 4; k++) begin
                wa[i][8*k +: 8] = 8'((i * 53 + k * 29 + 7) & 255);
                wb[i][8*k +: 8] = 8'((i * 91 + k * 17 + 3) & 255);
            end
        end
        g  = golden(16);
        p0 = dp_pulses;
        start_job(16);
        feed(16, 1'b1, -1, acc_n);
        wait_result();
        held = res_acc;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("t4_hold_valid", 32'(res_valid), 32'd1);
            check("t4_hold_acc", 32'(res_acc), 32'(held));
        end
        check("t4_res_acc", 32'(res_acc), 32'(g[ACC_W-1:0]));
        check("t4_res_ovf", 32'(res_ovf), 32'(g[ACC_W]));
        check("t4_dp_pulses", 32'(dp_pulses - p0), 32'd16);
        check("t4_outstanding_limit", 32'(occ_viol), 32'd0);
        take_result();

        // T5: abort after 4 of 10 words, flush, then a clean job.
        fill(10, 32'h03030303);
        p0 = dp_pulses;
        start_job(10);
        feed(10, 1'b0, 4, acc_n);
        check("t5_accepted", 32'(acc_n), 32'd4);
        in_valid = 1'b1;
        in_a     = wa[4];
        in_b     = wb[4];
        abort    = 1'b1;
        @(negedge clk);
        check("t5_ready_on_abort", 32'(in_ready), 32'd0);
        tick();
        abort    = 1'b0;
        check("t5_busy_flush", 32'(busy), 32'd1);
        check("t5_ready_flush", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        n = 0;
        saw_res = 1'b0;
        while (busy && n < 50) begin
            if (res_valid) saw_res = 1'b1;
            tick();
            n++;
        end
        check("t5_flush_exit", 32'(busy), 32'd0);
        check("t5_no_result", 32'(saw_res), 32'd0);
        check("t5_dp_pulses", 32'(dp_pulses - p0), 32'd4);
        fill(2, 32'h02020202);
        start_job(2);
        feed(2, 1'b0, -1, acc_n);
        wait_result();
        check("t5_res_acc", 32'(res_acc), 32'd32);
        check("t5_res_ovf", 32'(res_ovf), 32'd0);
        take_result();

        // T6: asynchronous reset mid-RUN, then a normal job.
        fill(4, 32'h01010101);
        start_job(4);
        feed(4, 1'b0, 2, acc_n);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_in_ready", 32'(in_ready), 32'd0);
        check("t6_dp_in_valid", 32'(dp_in_valid), 32'd0);
        check("t6_res_valid", 32'(res_valid), 32'd0);
        check("t6_res_acc", 32'(res_acc), 32'd0);
        check("t6_res_ovf", 32'(res_ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        fill(3, 32'h01010101);
        start_job(3);
        feed(3, 1'b0, -1, acc_n);
        wait_result();
        check("t6_res_acc_after", 32'(res_acc), 32'd12);
        check("t6_res_ovf_after", 32'(res_ovf), 32'd0);
        take_result();

        check("final_outstanding_limit", 32'(occ_viol), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
